// File: rtl/mem_port_arbiter.sv
// Round-robin share of one native memory port between core (0) and Ethernet DMA (1).
// Optional BUSY watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        owner,
  output logic        busy,
  output logic        timeout
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_e;

  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic        s_valid_q, s_valid_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [1:0]  rdy_q, rdy_d;
  logic [31:0] rd0_q, rd0_d;
  logic [31:0] rd1_q, rd1_d;
  logic        tmo_q, tmo_d;
  logic        expire;
  logic        gnt_vld;
  logic        gnt_sel;
  logic [31:0] resp_data;
  req_t        m0_req, m1_req;

  assign m0_req = '{instr: m0_instr, addr: m0_addr,
                    wdata: m0_wdata, wstrb: m0_wstrb};
  assign m1_req = '{instr: m1_instr, addr: m1_addr,
                    wdata: m1_wdata, wstrb: m1_wstrb};

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt_q, cnt_d;

  // Held at zero outside BUSY so every transfer starts from a clean count.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q != BUSY) begin
      cnt_d = '0;
    end else if (!s_ready) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (state_q == BUSY) && !s_ready && (cnt_q == CntLast);
`else
  assign expire = 1'b0;
`endif

  assign gnt_vld   = m0_valid | m1_valid;
  assign gnt_sel   = (m0_valid & m1_valid) ? ~last_q : m1_valid;
  assign resp_data = s_ready ? s_rdata : ERR_RDATA;

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    s_valid_d = s_valid_q;
    owner_d   = owner_q;
    last_d    = last_q;
    rdy_d     = 2'b00;
    rd0_d     = rd0_q;
    rd1_d     = rd1_q;
    tmo_d     = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          req_d     = gnt_sel ? m1_req : m0_req;
          owner_d   = gnt_sel;
          last_d    = gnt_sel;
          s_valid_d = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (s_ready || expire) begin
          if (owner_q) begin
            rd1_d    = resp_data;
            rdy_d[1] = 1'b1;
          end else begin
            rd0_d    = resp_data;
            rdy_d[0] = 1'b1;
          end
          tmo_d     = tmo_q | ~s_ready;
          s_valid_d = 1'b0;
          state_d   = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      s_valid_q <= 1'b0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      rdy_q     <= 2'b00;
      rd0_q     <= '0;
      rd1_q     <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      s_valid_q <= s_valid_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      rdy_q     <= rdy_d;
      rd0_q     <= rd0_d;
      rd1_q     <= rd1_d;
      tmo_q     <= tmo_d;
    end
  end

  assign s_valid  = s_valid_q;
  assign s_instr  = req_q.instr;
  assign s_addr   = req_q.addr;
  assign s_wdata  = req_q.wdata;
  assign s_wstrb  = req_q.wstrb;
  assign m0_ready = rdy_q[0];
  assign m1_ready = rdy_q[1];
  assign m0_rdata = rd0_q;
  assign m1_rdata = rd1_q;
  assign owner    = owner_q;
  assign busy     = (state_q != IDLE);
  assign timeout  = tmo_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester drivers, downstream responder,
// and a ready monitor that pops expected completions.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr, m0_ready;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic        m1_valid, m1_instr, m1_ready;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0]  m1_wstrb;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic        owner, busy, timeout;

  mem_port_arbiter #(
    .TIMEOUT_CYCLES(16),
    .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata),
    .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata),
    .s_valid(s_valid), .s_instr(s_instr), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .owner(owner), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          own;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] srd;
    logic [31:0] exp_rd;
  } txn_t;

  txn_t        sb[$];
  txn_t        mt;
  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          resp_delay = 1;
  int          wait_cnt = 0;
  int          ready_cyc = 0;
  int          issue_cyc[$];
  logic        late_ready = 1'b0;
  logic [31:0] last_rd[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic bad(input string nm, input logic [31:0] act);
    n_chk++;
    $display("FAIL %s: got %h want no event", nm, act);
  endtask

  function automatic txn_t mk(input bit own, input logic ins,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] srd,
                              input logic [31:0] erd);
    txn_t t;
    t.own = own; t.instr = ins; t.addr = a; t.wdata = d;
    t.wstrb = s; t.srd = srd; t.exp_rd = erd;
    return t;
  endfunction

  task automatic req(input bit p, input logic ins, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    logic rdy;
    if (p) begin
      m1_valid = 1'b1; m1_instr = ins; m1_addr = a;
      m1_wdata = d; m1_wstrb = s;
    end else begin
      m0_valid = 1'b1; m0_instr = ins; m0_addr = a;
      m0_wdata = d; m0_wstrb = s;
    end
    do begin
      @(posedge clk); #1;
      n++;
      rdy = p ? m1_ready : m0_ready;
    end while (!rdy && n < 200);
    if (!rdy) bad(p ? "req1_no_ready" : "req0_no_ready", 32'(n));
    if (p) m1_valid = 1'b0;
    else m0_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic chk_lat(input string nm, input int exp);
    if (issue_cyc.size() == 0) bad(nm, 32'(ready_cyc));
    else chk(nm, 32'(ready_cyc - issue_cyc[0]), 32'(exp));
  endtask

  // Downstream memory: answers resp_delay cycles after s_valid appears.
  initial begin
    s_ready = 1'b0;
    s_rdata = '0;
    forever begin
      @(posedge clk); #1;
      s_ready = late_ready;
      if (late_ready) s_rdata = 32'h0BAD_0BAD;
      if (s_valid) begin
        if (wait_cnt == 0) issue_cyc.push_back(cyc);
        if (wait_cnt == resp_delay) begin
          if (sb.size() == 0) begin
            bad("resp_no_expect", s_addr);
          end else begin
            s_ready = 1'b1;
            s_rdata = sb[0].srd;
            chk("s_addr", s_addr, sb[0].addr);
            chk("s_wdata", s_wdata, sb[0].wdata);
            chk("s_wstrb", 32'(s_wstrb), 32'(sb[0].wstrb));
            chk("s_instr", 32'(s_instr), 32'(sb[0].instr));
          end
        end
        wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Completion monitor.
  always @(negedge clk) begin
    if (reset) begin
      last_rd[0] = '0;
      last_rd[1] = '0;
    end else if (m0_ready || m1_ready) begin
      ready_cyc = cyc;
      if (sb.size() == 0) begin
        bad("unexpected_ready", 32'({m1_ready, m0_ready}));
      end else begin
        mt = sb.pop_front();
        chk("ready_port", 32'({m1_ready, m0_ready}),
            mt.own ? 32'd2 : 32'd1);
        chk("owner_rdata", mt.own ? m1_rdata : m0_rdata, mt.exp_rd);
        chk("other_rdata", mt.own ? m0_rdata : m1_rdata,
            last_rd[!mt.own]);
        last_rd[mt.own] = mt.exp_rd;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "simulation hung");
  end

  initial begin
    reset = 1'b1;
    m0_valid = 0; m0_instr = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 0; m1_instr = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_valid", 32'(s_valid), 0);
    chk("rst_s_instr", 32'(s_instr), 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_s_wdata", s_wdata, 0);
    chk("rst_s_wstrb", 32'(s_wstrb), 0);
    chk("rst_m0_ready", 32'(m0_ready), 0);
    chk("rst_m1_ready", 32'(m1_ready), 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout", 32'(timeout), 0);
    reset = 1'b0;
    tick();

    // Single read from requester 0, slave answers 3 cycles after s_valid.
    resp_delay = 3;
    issue_cyc.delete();
    sb.push_back(mk(0, 0, 32'h0000_1000, 32'h0, 4'h0,
                    32'h1234_5678, 32'h1234_5678));
    req(0, 0, 32'h0000_1000, 32'h0, 4'h0);
    tick();
    chk_lat("t1_latency", 4);

    // Contention from reset: grants 0,1,0,1 back to back.
    do_reset();
    resp_delay = 1;
    issue_cyc.delete();
    sb.push_back(mk(0, 0, 32'h2000, 32'h0, 4'h0, 32'h1111_0000, 32'h1111_0000));
    sb.push_back(mk(1, 1, 32'h3000, 32'hA5A5_5A5A, 4'hF,
                    32'h2222_0000, 32'h2222_0000));
    sb.push_back(mk(0, 1, 32'h2004, 32'h0, 4'h0, 32'h3333_0000, 32'h3333_0000));
    sb.push_back(mk(1, 0, 32'h3004, 32'h0102_0304, 4'h3,
                    32'h4444_0000, 32'h4444_0000));
    fork
      begin
        req(0, 0, 32'h2000, 32'h0, 4'h0);
        req(0, 1, 32'h2004, 32'h0, 4'h0);
      end
      begin
        req(1, 1, 32'h3000, 32'hA5A5_5A5A, 4'hF);
        req(1, 0, 32'h3004, 32'h0102_0304, 4'h3);
      end
    join
    tick();
    chk("rr_issue_count", 32'(issue_cyc.size()), 4);
    for (int i = 0; i < 3; i++) begin
      if (i + 1 < issue_cyc.size())
        chk("rr_issue_gap", 32'(issue_cyc[i+1] - issue_cyc[i]), 4);
    end

    // Requester 1 write; its inputs change while BUSY.
    resp_delay = 5;
    sb.push_back(mk(1, 0, 32'h4000_0010, 32'hCAFE_F00D, 4'hC,
                    32'h7777_0001, 32'h7777_0001));
    fork
      req(1, 0, 32'h4000_0010, 32'hCAFE_F00D, 4'hC);
      begin
        repeat (2) @(posedge clk);
        #2;
        m1_addr = 32'hFFFF_0000;
        m1_wdata = 32'h0;
        m1_wstrb = 4'hF;
        m1_instr = 1'b1;
        @(posedge clk); #1;
        chk("hold_s_addr", s_addr, 32'h4000_0010);
        chk("hold_s_wdata", s_wdata, 32'hCAFE_F00D);
        chk("hold_owner", 32'(owner), 1);
      end
    join
    tick();

    // Asynchronous reset in the middle of a requester 0 transfer.
    resp_delay = 1000;
    m0_valid = 1'b1; m0_instr = 0; m0_addr = 32'h5000;
    m0_wdata = '0; m0_wstrb = '0;
    tick();
    tick();
    chk("pre_rst_busy", 32'(busy), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_s_valid", 32'(s_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'({m1_ready, m0_ready}), 0);
    m0_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    resp_delay = 1;
    sb.push_back(mk(0, 0, 32'h5004, 32'h0, 4'h0, 32'h5555_0000, 32'h5555_0000));
    sb.push_back(mk(1, 0, 32'h6004, 32'h0, 4'h0, 32'h6666_0000, 32'h6666_0000));
    fork
      req(0, 0, 32'h5004, 32'h0, 4'h0);
      req(1, 0, 32'h6004, 32'h0, 4'h0);
    join
    tick();

`ifdef ARB_TIMEOUT_EN
    // Slave never answers: watchdog completes with the error word.
    do_reset();
    resp_delay = 1000;
    issue_cyc.delete();
    sb.push_back(mk(0, 0, 32'h7000, 32'h0, 4'h0, 32'h0, 32'hDEAD_BEEF));
    req(0, 0, 32'h7000, 32'h0, 4'h0);
    tick();
    chk_lat("tmo_latency", 16);
    chk("tmo_flag", 32'(timeout), 1);
    late_ready = 1'b1;
    tick();
    late_ready = 1'b0;
    repeat (3) tick();
    chk("late_busy", 32'(busy), 0);
    chk("late_flag", 32'(timeout), 1);
    do_reset();
    chk("tmo_cleared", 32'(timeout), 0);
    // Response on the expiry cycle wins.
    resp_delay = 15;
    issue_cyc.delete();
    sb.push_back(mk(1, 0, 32'h7004, 32'h1234_0000, 4'hF,
                    32'h600D_CAFE, 32'h600D_CAFE));
    req(1, 0, 32'h7004, 32'h1234_0000, 4'hF);
    tick();
    chk_lat("edge_latency", 16);
    chk("edge_flag", 32'(timeout), 0);
`else
    // No watchdog: a long wait still completes normally.
    resp_delay = 40;
    issue_cyc.delete();
    sb.push_back(mk(0, 0, 32'h7000, 32'h0, 4'h0, 32'h0F0F_0F0F, 32'h0F0F_0F0F));
    req(0, 0, 32'h7000, 32'h0, 4'h0);
    tick();
    chk_lat("long_latency", 41);
    chk("long_flag", 32'(timeout), 0);
`endif

    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
